// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data-memory access-type encodings and default depth.
package mips_pkg;

  localparam logic [2:0] MEMOP_WORD  = 3'd0;
  localparam logic [2:0] MEMOP_HALF  = 3'd1;
  localparam logic [2:0] MEMOP_HALFU = 3'd2;
  localparam logic [2:0] MEMOP_BYTE  = 3'd3;
  localparam logic [2:0] MEMOP_BYTEU = 3'd4;

  localparam int DM_DEPTH_DEFAULT = 3072;

  function automatic logic memop_legal(input logic [2:0] op);
    return (op <= MEMOP_BYTEU);
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Data-memory lane logic: store merge into the old word and load extension of the read word.
module dm_ext
  import mips_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_merged,
  output logic [31:0] o_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_old_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_old_word[31:16] : i_old_word[15:0];

  always_comb begin
    o_merged = i_old_word;
    case (i_op)
      MEMOP_HALF, MEMOP_HALFU: begin
        if (i_lane[1]) o_merged[31:16] = i_data[15:0];
        else           o_merged[15:0]  = i_data[15:0];
      end
      MEMOP_BYTE, MEMOP_BYTEU: o_merged[{i_lane, 3'b000} +: 8] = i_data[7:0];
      default:                 o_merged = i_data;
    endcase
  end

  // Illegal codes fall through to WORD; the top level flags and gates them.
  always_comb begin
    o_ext = i_old_word;
    case (i_op)
      MEMOP_HALF:  o_ext = {{16{w_half[15]}}, w_half};
      MEMOP_HALFU: o_ext = {16'h0000, w_half};
      MEMOP_BYTE:  o_ext = {{24{w_byte[7]}}, w_byte};
      MEMOP_BYTEU: o_ext = {24'h000000, w_byte};
      default:     o_ext = i_old_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: synchronous lane-merged stores, combinational extended loads, address-error flag.
// Optional store trace is compiled in with DM_TRACE_EN.
module mem_stage_dm
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = DM_DEPTH_DEFAULT,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_storeData,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemRead,
  input  logic [2:0]  MEM_MemOp,
  output logic [31:0] MEM_memRD,
  output logic        MEM_addrErr
);

  localparam int          IW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_off;
  logic [IW-1:0] w_idx;
  logic          w_in_range;
  logic          w_legal;
  logic          w_misaligned;
  logic          w_err;
  logic          w_we;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_merged;
  logic [31:0]   w_ext;

  assign w_off      = MEM_ALUOut - ADDR_BASE;
  assign w_in_range = (w_off < LIMIT);
  assign w_legal    = memop_legal(MEM_MemOp);

  always_comb begin
    w_misaligned = 1'b0;
    case (MEM_MemOp)
      MEMOP_HALF, MEMOP_HALFU: w_misaligned = w_off[0];
      MEMOP_BYTE, MEMOP_BYTEU: w_misaligned = 1'b0;
      default:                 w_misaligned = (w_off[1:0] != 2'b00);
    endcase
  end

  assign w_err       = (MEM_MemWrite | MEM_MemRead) & (w_misaligned | ~w_in_range | ~w_legal);
  assign MEM_addrErr = w_err;
  assign w_we        = MEM_MemWrite & ~w_err;

  // Out-of-range offsets are parked on word 0 so the read never leaves the array.
  assign w_idx     = w_in_range ? w_off[IW+1:2] : '0;
  assign w_rd_word = r_mem[w_idx];

  dm_ext u_ext (
    .i_old_word (w_rd_word),
    .i_data     (MEM_storeData),
    .i_op       (MEM_MemOp),
    .i_lane     (w_off[1:0]),
    .o_merged   (w_merged),
    .o_ext      (w_ext)
  );

  assign MEM_memRD = (MEM_MemRead && !w_err) ? w_ext : 32'h0000_0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[w_idx] <= w_merged;
`ifdef DM_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, MEM_pc, ADDR_BASE + {w_off[31:2], 2'b00}, w_merged);
`endif
    end
  end

`ifndef DM_TRACE_EN
  logic w_unused_pc;
  assign w_unused_pc = ^MEM_pc;
`endif

endmodule

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
- MEM-stage data memory of the five-stage MIPS pipeline. It sits directly upstream of the MEM/WB pipeline register and produces the MEM_memRD word that register captures.
- Performs word/half/byte stores with lane merging, and word/half/byte loads with sign or zero extension.
- Flags misaligned and out-of-range accesses.
- Array writes are synchronous; reads are combinational within the MEM cycle.

Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words (12 KiB).
- ADDR_BASE, 32'h0000_0000: byte address of word 0.

Ports:
- clk  input  1  pipeline clock; the array is written on the rising edge.
- reset  input  1  asynchronous, active-high; clears the whole array.
- MEM_pc  input  32  PC of the instruction in MEM; used only by the trace feature.
- MEM_ALUOut  input  32  effective byte address.
- MEM_storeData  input  32  forwarded rt value to be stored.
- MEM_MemWrite  input  1  store enable.
- MEM_MemRead  input  1  load enable.
- MEM_MemOp  input  3  access type (encodings in package).
- MEM_memRD  output  32  extended load result.
- MEM_addrErr  output  1  misaligned or out-of-range access.

Behaviour:
- MemOp encodings: 0 = WORD, 1 = HALF (signed), 2 = HALFU, 3 = BYTE (signed), 4 = BYTEU. Codes 5–7 are illegal: treated as WORD and MEM_addrErr asserted.
- Offset: off = MEM_ALUOut − ADDR_BASE. Word index = off[31:2]. Lane = off[1:0], little-endian; lane 0 is bits [7:0].
- Range check: in range iff off < 4*DEPTH_WORDS (unsigned compare).
- Alignment check:
  - WORD requires off[1:0] = 0.
  - HALF/HALFU requires off[0] = 0.
  - BYTE/BYTEU are always aligned.
- MEM_addrErr = (MemWrite | MemRead) & (misaligned | out of range | illegal op). It is combinational and 0 when neither enable is set.
- Store:
  - On posedge clk with MemWrite = 1 and addrErr = 0: array[idx] <= merged word.
  - BYTE/BYTEU replace lane off[1:0] with storeData[7:0].
  - HALF/HALFU replace half off[1] with storeData[15:0].
  - WORD replaces the whole word.
  - Other lanes keep their old value.
  - A store with addrErr = 1 is suppressed and leaves the array unchanged.
- Load:
  - MEM_memRD is combinational from array[idx], as the array stood before this cycle's edge.
  - WORD: the raw word.
  - HALF: sign-extends the selected half. HALFU: zero-extends it.
  - BYTE: sign-extends the selected byte. BYTEU: zero-extends it.
  - MEM_memRD = 0 when MemRead = 0 or addrErr = 1.
- Load and store in the same cycle (illegal in-ISA, but defined): the read returns the old contents and the write commits at the edge.
- Back-to-back: a load in cycle N+1 sees a store committed at the end of cycle N.
- Reset:
  - Asserting reset at any time clears every word to 0 immediately (asynchronously).
  - While reset is high, writes are blocked.
  - Given zero-filled memory: MEM_memRD = 0 after reset whenever MemRead = 0 or addrErr = 1, and also for any in-range aligned load (memory is zero-filled).
  - Deasserting reset takes effect on the next edge.
- No internal pipeline registers: latency 0 for reads, 1 edge for writes.

Optional Feature:
- DM_TRACE_EN defined: on every committed store, print $display("%d@%h: *%h <= %h", $time, MEM_pc, {word byte address}, merged word). The word byte address is ADDR_BASE + 4*idx.
  - Suppressed stores print nothing.
  - Reset clearing prints nothing.
- DM_TRACE_EN undefined: no display statements compiled; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg holds the MemOp localparams (MEMOP_WORD/HALF/HALFU/BYTE/BYTEU) and DM_DEPTH_DEFAULT.
- Sub-module dm_ext holds the combinational store-merge (old word, data, op, lane → new word) and load-extend (word, op, lane → result). It is instantiated once.
- The top level holds the array, range/alignment checks, and write control.

Test Plan:
- Reset, then WORD load at 0x0000 → memRD = 0, addrErr = 0.
- SW 0x8765_4321 @0x10, then LB @0x13 → 0xFFFF_FF87. Then LBU @0x13 → 0x0000_0087, LH @0x12 → 0xFFFF_8765, LHU @0x10 → 0x0000_4321.
- Word @0x20 = 0x1122_3344; SB data 0xAA @0x21 → word 0x1122_AA44. Then SH data 0xBEEF @0x22 → 0xBEEF_AA44.
- SW @0x06 (misaligned) and SW @0x3000 (DEPTH 3072, out of range) → addrErr = 1, memory unchanged, load of @0x04 still returns its prior value. LH @0x05 → addrErr = 1, memRD = 0.
- Store 0xDEAD_BEEF @0x40; assert reset asynchronously mid-cycle → load @0x40 returns 0 immediately. Store attempted during reset is not committed.
- With DM_TRACE_EN: SW 0x0000_00FF @0x44, pc 0x3008 → exactly one line "…@00003008: *00000044 <= 000000ff". A suppressed misaligned store prints none.
